// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit state type and frame constants
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Index width for a requester count; never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and serial line bundle
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx;
  logic                           busy;
  logic [ID_W-1:0]                grant_id;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick starting one past the previous winner
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index,
  output logic               any
);

  always_comb begin
    int   pos;
    logic found;
    pos   = 0;
    found = 1'b0;
    grant = '0;
    index = '0;
    // Offset NUM_REQ lands back on last_grant itself, so it is searched last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        index      = ID_W'(pos);
        grant[pos] = enable;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmit line among NUM_REQ byte requesters
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
) (
  input logic              clk_50m,
  input logic              rst_n,
  input logic              txclk_en,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_t          state;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  next_shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_id;
  logic               tx;
  logic               busy;
  logic               arb_en;
  logic               arb_any;
  logic               accept;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_index;

  // A new byte can only be taken on the tick that leaves IDLE or ends STOP.
  assign arb_en     = txclk_en && (state == IDLE || state == STOP);
  assign accept     = arb_en && arb_any;
  assign next_shift = shift_reg >> 1;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .last_grant(last_grant),
    .enable    (arb_en),
    .grant     (arb_grant),
    .index     (arb_index),
    .any       (arb_any)
  );

  assign bus.req_ready = arb_grant;
  assign bus.tx        = tx;
  assign bus.busy      = busy;
  assign bus.grant_id  = grant_id;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (txclk_en) begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            shift_reg  <= bus.req_data[arb_index];
            grant_id   <= arb_index;
            last_grant <= arb_index;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          tx      <= shift_reg[0];
        end
        DATA: begin
          shift_reg <= next_shift;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            tx <= next_shift[0];
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
